// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation frame loader.
// Holds the loader state encoding, memory depths and write-address widths.
package me_pkg;
  localparam int R_DEPTH = 256;   // reference block bytes (16x16)
  localparam int S_DEPTH = 1024;  // search window bytes (32x32)
  localparam int R_AW    = 8;     // reference memory address width
  localparam int S_AW    = 10;    // search memory address width
  localparam int IDX_W   = 10;    // shared fill index width

  typedef enum logic [2:0] {
    IDLE,
    LOAD_R,
    LOAD_S,
    RUN,
    DONE
  } loader_state_t;
endpackage

// File: rtl/me_wr_port.sv
// Registered memory write stage: strobe, address and data are captured
// together, so the memory sees them one cycle after the loader decides to write.
// Ports:
//   clock, reset        - clock, async active-low reset
//   en_i/addr_i/data_i  - write request from the loader
//   wr_en/wr_addr/wr_data - registered write port to the memory
module me_wr_port #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
);
  logic          en_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q <= en_i;
      // Address/data only move on a write; they are don't-care otherwise.
      if (en_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
    end
  end

  assign wr_en   = en_q;
  assign wr_addr = addr_q;
  assign wr_data = data_q;
endmodule

// File: rtl/me_frame_loader.sv
// Writer side of the motion-estimation memories. Streams pixel beats into the
// reference block memory, then the search window memory, then holds me_start
// until the estimator reports completion.
// Ports:
//   clock, reset                    - clock, async active-low reset
//   pix_data/pix_valid/pix_sof      - incoming pixel stream
//   pix_ready                       - loader accepts a beat
//   wr_en_r/wr_addr_r/wr_data_r     - reference memory write port
//   wr_en_s/wr_addr_s/wr_data_s     - search memory write port
//   me_start, me_completed          - estimator start/completion levels
//   frame_done                      - one-cycle pulse per finished frame
//   sof_error                       - sticky early-sof flag
//   frame_count                     - completed frames, wraps
module me_frame_loader #(
  parameter int DATA_W  = 8,
  parameter int R_DEPTH = me_pkg::R_DEPTH,
  parameter int S_DEPTH = me_pkg::S_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_valid,
  input  logic              pix_sof,
  output logic              pix_ready,
  output logic              wr_en_r,
  output logic [7:0]        wr_addr_r,
  output logic [DATA_W-1:0] wr_data_r,
  output logic              wr_en_s,
  output logic [9:0]        wr_addr_s,
  output logic [DATA_W-1:0] wr_data_s,
  output logic              me_start,
  input  logic              me_completed,
  output logic              frame_done,
  output logic              sof_error,
  output logic [7:0]        frame_count
);
  import me_pkg::*;

  localparam logic [IDX_W-1:0] R_LAST = IDX_W'(R_DEPTH - 1);
  localparam logic [IDX_W-1:0] S_LAST = IDX_W'(S_DEPTH - 1);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pix_ready_q, pix_ready_d;
  logic             me_start_q, me_start_d;
  logic             sof_error_q, sof_error_d;
  logic [7:0]       frame_count_q, frame_count_d;

  logic             wr_r, wr_s;
  logic [R_AW-1:0]  addr_r;
  logic [S_AW-1:0]  addr_s;
  logic             accept;

  assign accept = pix_valid & pix_ready_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sof_error_d   = sof_error_q;
    frame_count_d = frame_count_q;
    wr_r          = 1'b0;
    wr_s          = 1'b0;
    addr_r        = idx_q[R_AW-1:0];
    addr_s        = idx_q[S_AW-1:0];

    unique case (state_q)
      IDLE: begin
        // Non-sof beats are swallowed until a frame starts.
        if (accept && pix_sof) begin
          wr_r    = 1'b1;
          addr_r  = '0;
          idx_d   = IDX_W'(1);
          state_d = LOAD_R;
        end
      end
      LOAD_R, LOAD_S: begin
        if (accept) begin
          if (pix_sof && !(state_q == LOAD_R && idx_q == '0)) begin
            // Early sof: this beat becomes R[0] of a fresh frame.
            wr_r        = 1'b1;
            addr_r      = '0;
            idx_d       = IDX_W'(1);
            state_d     = LOAD_R;
            sof_error_d = 1'b1;
          end else if (state_q == LOAD_R) begin
            wr_r = 1'b1;
            if (idx_q == R_LAST) begin
              idx_d   = '0;
              state_d = LOAD_S;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            wr_s = 1'b1;
            if (idx_q == S_LAST) begin
              idx_d   = '0;
              state_d = RUN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      RUN: begin
        if (me_completed) begin
          state_d       = DONE;
          frame_count_d = frame_count_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pix_ready_d = (state_d == IDLE) || (state_d == LOAD_R) || (state_d == LOAD_S);
    // Registered from the first RUN cycle, so me_start trails the final
    // search write by one cycle and drops together with the DONE entry.
    me_start_d  = (state_q == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      pix_ready_q   <= 1'b0;
      me_start_q    <= 1'b0;
      sof_error_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pix_ready_q   <= pix_ready_d;
      me_start_q    <= me_start_d;
      sof_error_q   <= sof_error_d;
      frame_count_q <= frame_count_d;
    end
  end

  me_wr_port #(.AW(R_AW), .DW(DATA_W)) u_wr_r (
    .clock   (clock),
    .reset   (reset),
    .en_i    (wr_r),
    .addr_i  (addr_r),
    .data_i  (pix_data),
    .wr_en   (wr_en_r),
    .wr_addr (wr_addr_r),
    .wr_data (wr_data_r)
  );

  me_wr_port #(.AW(S_AW), .DW(DATA_W)) u_wr_s (
    .clock   (clock),
    .reset   (reset),
    .en_i    (wr_s),
    .addr_i  (addr_s),
    .data_i  (pix_data),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s)
  );

  assign pix_ready   = pix_ready_q;
  assign me_start    = me_start_q;
  assign frame_done  = (state_q == DONE);
  assign sof_error   = sof_error_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_me_frame_loader.sv
module tb_me_frame_loader;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic       pix_ready;
  logic       wr_en_r, wr_en_s;
  logic [7:0] wr_addr_r, wr_data_r, wr_data_s;
  logic [9:0] wr_addr_s;
  logic       me_start;
  logic       me_completed = 1'b0;
  logic       frame_done, sof_error;
  logic [7:0] frame_count;

  me_frame_loader dut (
    .clock(clock), .reset(reset),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_ready(pix_ready),
    .wr_en_r(wr_en_r), .wr_addr_r(wr_addr_r), .wr_data_r(wr_data_r),
    .wr_en_s(wr_en_s), .wr_addr_s(wr_addr_s), .wr_data_s(wr_data_s),
    .me_start(me_start), .me_completed(me_completed),
    .frame_done(frame_done), .sof_error(sof_error), .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_s;
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_err = 0;

  // Reference model: linear position within the 1280-byte frame, -1 outside.
  int  pos = -1;
  bit  loaded = 0;
  bit  exp_err = 0;
  bit  exp_done = 0;
  int  model_frames = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_accept(input logic [7:0] d, input logic s);
    wr_t w;
    if (s) begin
      if (pos > 0) exp_err = 1;
      pos = 0;
    end
    if (pos < 0) return;
    w.is_s = (pos >= 256);
    w.addr = (pos >= 256) ? pos - 256 : pos;
    w.data = d;
    exp_q.push_back(w);
    pos++;
    if (pos == 1280) begin
      loaded = 1;
      pos = -1;
    end
  endfunction

  // Monitor / scoreboard
  initial begin
    bit  prev_ws = 0;
    bit  prev_start = 0;
    wr_t e;
    forever begin
      @(negedge clock);
      if (wr_en_r || wr_en_s) begin
        check("wr_exclusive", {31'b0, wr_en_r & wr_en_s}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_write: r=%0b s=%0b addr_r=%0d addr_s=%0d, none expected",
                   wr_en_r, wr_en_s, wr_addr_r, wr_addr_s);
        end else begin
          e = exp_q.pop_front();
          check("wr_sel_s", {31'b0, wr_en_s}, {31'b0, e.is_s});
          check("wr_addr", wr_en_s ? {22'b0, wr_addr_s} : {24'b0, wr_addr_r}, e.addr);
          check("wr_data", wr_en_s ? {24'b0, wr_data_s} : {24'b0, wr_data_r}, {24'b0, e.data});
        end
      end
      if (me_start && !prev_start) begin
        check("start_after_last_ws", {29'b0, loaded, prev_ws, exp_q.size() == 0}, 32'd7);
        loaded = 0;
      end
      if (frame_done) check("done_expected", {31'b0, exp_done}, 32'd1);
      prev_ws = wr_en_s;
      prev_start = me_start;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic send_beat(input logic [7:0] d, input logic s, input int duty);
    int   waited = 0;
    logic acc = 0;
    while (duty < 100 && $urandom_range(0, 99) >= duty) begin
      pix_valid = 0; pix_sof = 0;
      @(negedge clock);
    end
    pix_valid = 1; pix_data = d; pix_sof = s;
    while (!acc) begin
      acc = pix_ready;
      if (acc) model_accept(d, s);
      @(negedge clock);
      if (!acc) begin
        waited++;
        if (waited > 2000) begin
          check("beat_accept_timeout", 32'd0, 32'd1);
          break;
        end
      end
    end
  endtask

  // mode 0: R[i]=i, S[j]=j[7:0]; mode 1: random bytes
  task automatic send_frame(input int mode, input int duty);
    for (int i = 0; i < 1280; i++)
      send_beat(mode != 0 ? 8'($urandom) : 8'(i), i == 0, duty);
    pix_valid = 0; pix_sof = 0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!me_start && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("me_start_rise", {31'b0, me_start}, 32'd1);
  endtask

  task automatic finish_frame();
    wait_start();
    repeat (3) @(negedge clock);
    check("ready_low_in_run", {31'b0, pix_ready}, 32'd0);
    check("start_held", {31'b0, me_start}, 32'd1);
    exp_done = 1;
    model_frames++;
    me_completed = 1;
    @(negedge clock);
    me_completed = 0;
    check("frame_done_pulse", {31'b0, frame_done}, 32'd1);
    check("start_low_in_done", {31'b0, me_start}, 32'd0);
    check("frame_count", {24'b0, frame_count}, model_frames & 8'hff);
    exp_done = 0;
    @(negedge clock);
    check("ready_after_done", {31'b0, pix_ready}, 32'd1);
    check("done_one_cycle", {31'b0, frame_done}, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2;
    check("rst_ready", {31'b0, pix_ready}, 32'd0);
    check("rst_outputs", {28'b0, wr_en_r, wr_en_s, me_start, frame_done}, 32'd0);
    check("rst_err_cnt", {23'b0, sof_error, frame_count}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    check("ready_after_rst", {31'b0, pix_ready}, 32'd1);

    // Pre-sof garbage, then a back-to-back counting frame
    for (int i = 0; i < 5; i++) send_beat(8'($urandom), 1'b0, 100);
    send_frame(0, 100);
    finish_frame();
    check("no_sof_err", {31'b0, sof_error}, {31'b0, exp_err});

    // Early sof after 100 reference beats
    for (int i = 0; i < 100; i++) send_beat(8'($urandom), i == 0, 100);
    send_beat(8'hAA, 1'b1, 100);
    check("sof_err_set", {31'b0, sof_error}, 32'd1);
    for (int i = 1; i < 1280; i++) send_beat(8'($urandom), 1'b0, 100);
    pix_valid = 0; pix_sof = 0;
    finish_frame();
    check("sof_err_sticky", {31'b0, sof_error}, {31'b0, exp_err});

    // Gappy stream at ~30% valid duty
    send_frame(0, 30);
    finish_frame();

    // Async reset in the middle of RUN
    send_frame(1, 100);
    wait_start();
    @(posedge clock);
    #2 reset = 0;
    #1;
    check("arst_start_drop", {31'b0, me_start}, 32'd0);
    check("arst_ready_drop", {31'b0, pix_ready}, 32'd0);
    check("arst_count", {24'b0, frame_count}, 32'd0);
    check("arst_sof_err", {31'b0, sof_error}, 32'd0);
    pos = -1; loaded = 0; exp_err = 0; model_frames = 0;
    @(negedge clock);
    check("arst_no_done", {31'b0, frame_done}, 32'd0);
    reset = 1;
    @(negedge clock);
    check("ready_after_arst", {31'b0, pix_ready}, 32'd1);
    send_frame(1, 100);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/me_frame_loader.md
Name: me_frame_loader

Overview:
Writer side of the motion-estimation memories. Accepts a byte stream of pixels with a valid/ready handshake. Fills the 256-byte reference block memory, then the 1024-byte search-window memory. Once both memories are loaded, it holds the estimator start level until the estimator reports completion, then re-arms for the next frame.

Parameters:
DATA_W, 8, pixel width in bits
R_DEPTH, 256, reference block bytes (16x16)
S_DEPTH, 1024, search window bytes (32x32)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
pix_data  in  DATA_W  incoming pixel byte
pix_valid  in  1  pix_data valid
pix_sof  in  1  start-of-frame marker, qualified by pix_valid
pix_ready  out  1  loader can accept a beat
wr_en_r  out  1  reference memory write strobe
wr_addr_r  out  8  reference memory write address
wr_data_r  out  DATA_W  reference memory write data
wr_en_s  out  1  search memory write strobe
wr_addr_s  out  10  search memory write address
wr_data_s  out  DATA_W  search memory write data
me_start  out  1  start level to estimator control; held high while running
me_completed  in  1  estimator completion level
frame_done  out  1  one-cycle pulse when a frame's estimation finishes
sof_error  out  1  sticky; a frame was restarted by an early sof
frame_count  out  8  number of completed frames, wraps 255->0

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0, except pix_ready, which is 1 from the first clock after reset is released. Counters are cleared.
- Beat accepted when pix_valid & pix_ready at a rising edge.
- States: IDLE, LOAD_R, LOAD_S, RUN, DONE.
- IDLE:
  - pix_ready=1.
  - Beats with pix_sof=0 are accepted and discarded.
  - A beat with pix_sof=1 is written as R[0]; next state is LOAD_R with idx=1.
- LOAD_R:
  - pix_ready=1.
  - Each beat writes R[idx], then idx increments.
  - When the beat at idx=255 is accepted, next state is LOAD_S with idx=0.
- LOAD_S:
  - pix_ready=1.
  - Each beat writes S[idx].
  - When the beat at idx=1023 is accepted, next state is RUN.
- Write timing:
  - Write ports are registered, so wr_en_* pulses for one cycle, exactly one cycle after acceptance.
  - Address and data are valid with the strobe.
  - wr_en_r and wr_en_s are never high together.
- RUN:
  - pix_ready=0.
  - me_start rises on the cycle after the final wr_en_s pulse, so the last search byte is committed before the estimator starts.
  - me_start stays high while me_completed=0.
  - When me_completed=1 is sampled, next state is DONE.
- DONE (one cycle):
  - me_start=0, frame_done=1.
  - frame_count increments.
  - Next state is IDLE.
  - me_start is low for at least one cycle between frames, which clears the estimator counter.
- Early sof: a sof=1 beat accepted in LOAD_R or LOAD_S (other than idx 0 of LOAD_R) restarts the frame.
  - That beat is written as R[0] and idx becomes 1; state is LOAD_R.
  - sof_error is set and stays set until reset.
- Beats in RUN/DONE are not accepted (pix_ready=0). Upstream must hold them.
- me_completed is ignored outside RUN.
- pix_valid gaps: the loader stalls indefinitely with no timeout; idx is preserved.
- Reset during LOAD or RUN aborts immediately: me_start drops asynchronously and no partial-frame frame_done is produced.
- Counter widths: idx is 10 bits. wr_addr_r uses idx[7:0] and is not incremented past 255.

Decomposition:
- Shared package me_pkg:
  - State enum loader_state_t {IDLE, LOAD_R, LOAD_S, RUN, DONE}.
  - Constants R_DEPTH=256, S_DEPTH=1024, and the address widths 8 and 10.
- One natural sub-module, me_wr_port: a registered write-strobe/address/data stage. It is instantiated twice, once for the R memory and once for the S memory.

Test Plan:
- Basic load: release reset, stream 1280 beats back-to-back with sof on beat 0 (R[i]=i, S[j]=j[7:0]), hold me_completed=0 -> 256 wr_en_r pulses at addresses 0..255, then 1024 wr_en_s pulses at 0..1023; me_start rises 1 cycle after the last wr_en_s; pix_ready=0 while me_start=1.
- Completion: in RUN, assert me_completed for 1 cycle -> next cycle frame_done=1 and me_start=0, frame_count=1; the following cycle pix_ready=1.
- Pre-sof garbage: in IDLE send 5 beats with sof=0, then a sof frame -> no writes for the first 5 beats; the first write is wr_addr_r=0 with the sof beat's data.
- Early sof: after 100 R beats, send a beat with sof=1 and data 0xAA -> wr_addr_r=0, wr_data_r=0xAA, sof_error=1; a full 1280 more beats are still required before me_start rises.
- Backpressure/gaps: random pix_valid at 30% duty -> identical write contents and order to the back-to-back case, with no dropped or duplicated addresses.
- Async reset mid-RUN: pull reset low between clock edges -> me_start and pix_ready drop immediately; no frame_done; frame_count=0; after release, the next sof frame loads from R[0].
